// File: rtl/clock_div_pkg.sv
// Shared types, reset defaults and helpers for the multi-channel clock divider.
package clock_div_pkg;

  localparam int CNT_NBITS_DFLT = 8;
  localparam int RST_DIV_DFLT   = 4;
  localparam int RST_HIGH_DFLT  = 2;

  typedef logic [CNT_NBITS_DFLT-1:0] cnt_t;

  typedef struct packed {
    cnt_t div;
    cnt_t high;
  } chan_cfg_t;

  // A channel-index port stays at least one bit wide, even for a single channel.
  function automatic int idx_nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, active/pending configuration, and
// registered clk_out / tick / pend outputs.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int p_cnt_nbits = CNT_NBITS_DFLT,
  parameter int p_rst_div   = RST_DIV_DFLT,
  parameter int p_rst_high  = RST_HIGH_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   align,
  input  logic                   wr,
  input  logic [p_cnt_nbits-1:0] wr_div,
  input  logic [p_cnt_nbits-1:0] wr_high,
  output logic                   clk_out,
  output logic                   tick,
  output logic                   pend
);

  typedef logic [p_cnt_nbits-1:0] cnt_w_t;
  typedef struct packed {
    cnt_w_t div;
    cnt_w_t high;
  } cfg_t;

  localparam cfg_t RST_CFG = '{div: cnt_w_t'(p_rst_div), high: cnt_w_t'(p_rst_high)};

  cfg_t   act_reg, act_next;
  cfg_t   pnd_reg, pnd_next;
  cnt_w_t cnt_reg, cnt_next;
  logic   clk_out_reg, clk_out_next;
  logic   tick_reg, tick_next;
  logic   pend_reg, pend_next;

  logic                 running;
  logic                 wrap;
  logic                 apply;
  logic [p_cnt_nbits:0] hi_sum;

  always_comb begin
    pnd_next = wr ? '{div: wr_div, high: wr_high} : pnd_reg;
    running  = en && (act_reg.div > cnt_w_t'(1));
    wrap     = cnt_reg >= (act_reg.div - cnt_w_t'(1));
    // Config only changes where a period boundary exists: wrap, stop, or align.
    apply    = !running || wrap || align;
    act_next = apply ? pnd_next : act_reg;
    if (apply) begin
      pend_next = 1'b0;
    end else begin
      pend_next = wr ? 1'b1 : pend_reg;
    end
    if (!running || align || wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + cnt_w_t'(1);
    end
    // cnt >= d - h rewritten as cnt + h >= d so h >= d needs no signed math.
    hi_sum       = {1'b0, cnt_next} + {1'b0, act_next.high};
    clk_out_next = running && !align && (act_next.div > cnt_w_t'(1)) &&
                   (hi_sum >= {1'b0, act_next.div});
    tick_next    = clk_out_next && !clk_out_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_reg     <= RST_CFG;
      pnd_reg     <= RST_CFG;
      cnt_reg     <= '0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      pend_reg    <= 1'b0;
    end else begin
      act_reg     <= act_next;
      pnd_reg     <= pnd_next;
      cnt_reg     <= cnt_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
      pend_reg    <= pend_next;
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign pend    = pend_reg;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with glitch-free reconfiguration.
// Optional CLOCK_DIV_MULTI_ALIGN_EN adds an 'align' input that phase-aligns all channels.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int p_nchan     = 4,
  parameter int p_cnt_nbits = CNT_NBITS_DFLT,
  parameter int p_rst_div   = RST_DIV_DFLT,
  parameter int p_rst_high  = RST_HIGH_DFLT
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic [p_nchan-1:0]            en,
`ifdef CLOCK_DIV_MULTI_ALIGN_EN
  input  logic                          align,
`endif
  input  logic                          wr_en,
  input  logic [idx_nbits(p_nchan)-1:0] wr_chan,
  input  logic [p_cnt_nbits-1:0]        wr_div,
  input  logic [p_cnt_nbits-1:0]        wr_high,
  output logic [p_nchan-1:0]            clk_out,
  output logic [p_nchan-1:0]            tick,
  output logic [p_nchan-1:0]            pend
);

  localparam int CH_W = idx_nbits(p_nchan);

  logic align_int;
`ifdef CLOCK_DIV_MULTI_ALIGN_EN
  assign align_int = align;
`else
  assign align_int = 1'b0;
`endif

  // Indices at or above p_nchan match no channel, so such writes are dropped.
  generate
    for (genvar gi = 0; gi < p_nchan; gi++) begin : g_chan
      clock_div_chan #(
        .p_cnt_nbits (p_cnt_nbits),
        .p_rst_div   (p_rst_div),
        .p_rst_high  (p_rst_high)
      ) u_chan (
        .clk     (clk_in),
        .rst     (rst),
        .en      (en[gi]),
        .align   (align_int),
        .wr      (wr_en && (wr_chan == CH_W'(gi))),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .clk_out (clk_out[gi]),
        .tick    (tick[gi]),
        .pend    (pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_div_multi.sv
// Bench for clock_div_multi: period-level reference model checked every cycle,
// plus directed waveform captures. Define CLOCK_DIV_MULTI_ALIGN_EN to cover align.
module tb_clock_div_multi;

  localparam int NCH = 3;
  localparam int NB  = 8;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [NCH-1:0] en;
  logic          align;
  logic          wr_en;
  logic [1:0]    wr_chan;
  logic [NB-1:0] wr_div;
  logic [NB-1:0] wr_high;
  logic [NCH-1:0] clk_out, tick, pend;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  clock_div_multi #(
    .p_nchan(NCH), .p_cnt_nbits(NB), .p_rst_div(4), .p_rst_high(2)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
`ifdef CLOCK_DIV_MULTI_ALIGN_EN
    .align   (align),
`endif
    .wr_en   (wr_en),
    .wr_chan (wr_chan),
    .wr_div  (wr_div),
    .wr_high (wr_high),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current period plus active/pending settings.
  int m_d[NCH], m_h[NCH], m_pd[NCH], m_ph[NCH], m_pos[NCH];
  logic [NCH-1:0] m_out, m_tick, m_pend;
  logic align_v;

`ifdef CLOCK_DIV_MULTI_ALIGN_EN
  assign align_v = align;
`else
  assign align_v = 1'b0;
`endif

  initial forever begin
    @(posedge clk_in or posedge rst);
    for (int c = 0; c < NCH; c++) begin
      bit wrc, run, nxt;
      if (rst) begin
        m_d[c] = 4; m_h[c] = 2; m_pd[c] = 4; m_ph[c] = 2; m_pos[c] = 0;
        m_out[c] = 1'b0; m_tick[c] = 1'b0; m_pend[c] = 1'b0;
      end else begin
        wrc = wr_en && (int'(wr_chan) == c);
        if (wrc) begin
          m_pd[c] = int'(wr_div);
          m_ph[c] = int'(wr_high);
        end
        run = en[c] && (m_d[c] >= 2);
        if (!run || align_v || (m_pos[c] == m_d[c] - 1)) begin
          m_d[c] = m_pd[c]; m_h[c] = m_ph[c]; m_pend[c] = 1'b0; m_pos[c] = 0;
        end else begin
          m_pos[c] = m_pos[c] + 1;
          if (wrc) m_pend[c] = 1'b1;
        end
        nxt = run && !align_v && (m_d[c] >= 2) && (m_pos[c] >= m_d[c] - m_h[c]);
        m_tick[c] = nxt && !m_out[c];
        m_out[c]  = nxt;
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (chk_on) begin
      check("cmp_clk_out", 32'(clk_out), 32'(m_out));
      check("cmp_tick",    32'(tick),    32'(m_tick));
      check("cmp_pend",    32'(pend),    32'(m_pend));
    end
  end

  logic [31:0] cap_co[NCH], cap_tk[NCH], cap_pd[NCH];

  // Shift in n samples, the current negedge first; first sample ends up in the MSB.
  task automatic capture(input int n);
    for (int c = 0; c < NCH; c++) begin
      cap_co[c] = '0; cap_tk[c] = '0; cap_pd[c] = '0;
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk_in);
      for (int c = 0; c < NCH; c++) begin
        cap_co[c] = {cap_co[c][30:0], clk_out[c]};
        cap_tk[c] = {cap_tk[c][30:0], tick[c]};
        cap_pd[c] = {cap_pd[c][30:0], pend[c]};
      end
    end
  endtask

  task automatic do_write(input int ch, input int d, input int h);
    $display("write: ch=%0d d=%0d h=%0d at %0t", ch, d, h, $time);
    wr_en = 1'b1; wr_chan = 2'(ch); wr_div = 8'(d); wr_high = 8'(h);
    @(posedge clk_in); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_pend_clear(input int ch);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (pend[ch] == 1'b0) break;
    end
    check("apply_wait", 32'(i < 20), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = '0; align = 1'b0;
    wr_en = 1'b0; wr_chan = '0; wr_div = '0; wr_high = '0;

    repeat (3) @(posedge clk_in); #1;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_pend",    32'(pend),    32'd0);

    rst = 1'b0; en = '1; chk_on = 1'b1;
    @(negedge clk_in);
    capture(8);
    check("dflt_ch0_wave", cap_co[0], 32'b00110011);
    check("dflt_ch0_tick", cap_tk[0], 32'b00100010);
    check("dflt_ch1_wave", cap_co[1], 32'b00110011);
    check("dflt_pend",     cap_pd[0] | cap_pd[1], 32'd0);

    // Mid-period write on ch1 (cnt=1): old period completes first.
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    do_write(1, 6, 1);
    @(negedge clk_in);
    capture(14);
    check("wr_ch1_wave", cap_co[1], 32'b11000001000001);
    check("wr_ch1_pend", cap_pd[1], 32'b11000000000000);
    check("wr_ch0_wave", cap_co[0], 32'b11001100110011);

    do_write(3, 2, 1);
    check("bad_chan_pend", 32'(pend), 32'd0);

    @(negedge clk_in);
    do_write(0, 5, 0);
    wait_pend_clear(0);
    capture(12);
    check("h0_wave", cap_co[0], 32'd0);
    check("h0_tick", cap_tk[0], 32'd0);

    do_write(0, 5, 7);
    wait_pend_clear(0);
    capture(12);
    check("hbig_wave", cap_co[0], 32'hFFF);
    check("hbig_tick", cap_tk[0], 32'b100000000000);

    do_write(0, 1, 2);
    wait_pend_clear(0);
    capture(12);
    check("d1_wave", cap_co[0], 32'd0);
    check("d1_tick", cap_tk[0], 32'd0);

    do_write(0, 4, 2);
    check("stopped_apply_pend", 32'(pend[0]), 32'd0);
    @(negedge clk_in);
    capture(8);
    check("restore_wave", cap_co[0], 32'b00110011);

    // Drop enable while the output is high, then re-enable.
    for (int i = 0; i < 20 && !clk_out[0]; i++) @(negedge clk_in);
    check("en_drop_setup", 32'(clk_out[0]), 32'd1);
    en[0] = 1'b0;
    @(negedge clk_in);
    check("en_drop_clk_out", 32'(clk_out[0]), 32'd0);
    check("en_drop_tick",    32'(tick[0]),    32'd0);
    repeat (3) @(negedge clk_in);
    en[0] = 1'b1;
    capture(8);
    check("reen_wave", cap_co[0], 32'b00110011);

    // Async reset mid-period with a write still pending.
    for (int i = 0; i < 20 && !tick[0]; i++) @(negedge clk_in);
    check("rst_setup_tick", 32'(tick[0]), 32'd1);
    do_write(0, 7, 3);
    check("rst_setup_pend", 32'(pend[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_clk_out", 32'(clk_out), 32'd0);
    check("async_tick",    32'(tick),    32'd0);
    check("async_pend",    32'(pend),    32'd0);
    repeat (2) @(posedge clk_in); #1;
    rst = 1'b0;
    @(negedge clk_in);
    capture(8);
    check("post_rst_wave", cap_co[0], 32'b00110011);
    check("post_rst_pend", cap_pd[0], 32'd0);

`ifdef CLOCK_DIV_MULTI_ALIGN_EN
    @(negedge clk_in);
    do_write(1, 8, 4);
    repeat (20) @(negedge clk_in);
    align = 1'b1;
    $display("align pulse at %0t", $time);
    do_write(2, 6, 3);
    align = 1'b0;
    @(negedge clk_in);
    capture(6);
    check("align_ch0_wave", cap_co[0], 32'b001100);
    check("align_ch1_wave", cap_co[1], 32'b000011);
    check("align_ch2_wave", cap_co[2], 32'b000111);
    check("align_ch2_pend", cap_pd[2], 32'd0);
`endif

    repeat (4) @(negedge clk_in);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Multi-channel programmable clock divider; successor to the single fixed-factor divider.
- Each channel derives a divided clock-enable-style waveform from clk_in, with:
  - runtime divisor and high-time (duty) programming;
  - per-channel enable;
  - a rising-edge tick.
- Divisor changes are glitch-free: new settings apply only at a period boundary.
- Sits between the top-level clock and peripheral blocks (display scan, debouncers, timers) that need slow strobes.

Parameters:
- p_nchan, 4, number of independent output channels (1..16).
- p_cnt_nbits, 8, width of divisor/high-time fields and per-channel counter.
- p_rst_div, 4, divisor loaded into every channel on reset (must be ≥2 and < 2^p_cnt_nbits).
- p_rst_high, 2, high-time loaded into every channel on reset.

Ports:
- clk_in  input  1  sole clock.
- rst  input  1  reset; asynchronous, active-high.
- en  input  p_nchan  per-channel run enable.
- wr_en  input  1  config write strobe, one cycle.
- wr_chan  input  $clog2(p_nchan) (min 1)  channel index for write.
- wr_div  input  p_cnt_nbits  new divisor d (period in clk_in cycles).
- wr_high  input  p_cnt_nbits  new high-time h (cycles high per period).
- clk_out  output  p_nchan  registered divided outputs.
- tick  output  p_nchan  one-cycle pulse, high in the cycle clk_out goes 0→1.
- pend  output  p_nchan  1 while a channel holds an unapplied config write.

Behaviour:
- Reset (async, rst=1):
  - active d=p_rst_div, h=p_rst_high;
  - pending regs = same values; cnt=0;
  - clk_out=0, tick=0, pend=0.
- Per channel, registered counter cnt runs 0..d-1 while en=1, then wraps to 0.
- clk_out (registered) = 1 iff cnt ≥ d-h, evaluated on the value cnt holds in that cycle. The output is therefore low-first then high.
- Example: d=4, h=2 from reset gives clk_out 0,0,1,1,0,0,1,1…
- tick = clk_out & ~clk_out_prev, also registered.
- Degenerate settings:
  - h=0: clk_out constant 0, no ticks.
  - h≥d: clk_out constant 1 (one tick when entering high).
  - d<2: channel treated as stopped; cnt held 0, clk_out=0, tick=0.
- Config write (wr_en=1):
  - latches wr_div/wr_high into the pending regs of wr_chan and sets pend.
  - wr_chan ≥ p_nchan is ignored.
  - Multiple writes before a boundary: last wins.
- Apply rule:
  - Pending values become active on the wrap edge (cnt==d-1 → 0); pend clears on that same edge.
  - A write in the wrap cycle itself is applied on that wrap edge.
  - If en=0, pending values apply on the next edge.
- en=0: cnt forced to 0, clk_out=0, tick=0.
- Re-enable: period restarts at cnt=0 and the output starts low.
- Async rst mid-period: immediately returns to reset state; pending writes are discarded.
- All channels are independent; no cross-channel ordering.

Optional Feature:
- Macro: CLOCK_DIV_MULTI_ALIGN_EN.
- When defined, adds input port `align` (1 bit). A one-cycle pulse on the next edge:
  - forces cnt=0 on every enabled channel;
  - applies all pending configs and clears pend;
  - sets clk_out=0.
  All channels are thus phase-aligned.
- If align and wr_en occur in the same cycle, the write is applied by the align.
- When undefined, the port is absent and channels free-run from their own enable/reset.

Decomposition:
- Package clock_div_pkg:
  - cnt_t typedef (p_cnt_nbits-wide logic);
  - chan_cfg_t struct {div, high};
  - reset-value constants.
- Sub-module clock_div_chan: one channel containing counter, active/pending cfg, clk_out/tick/pend logic.
- Top-level clock_div_multi: generate loop plus write-index decode.

Test Plan:
- Reset defaults, p_nchan=2, en=2'b11 after reset release → each clk_out 0,0,1,1,0,0,1,1; tick high in cycles 2 and 6; pend=0.
- Write ch1 d=6 h=1 mid-period (cnt=1) → ch1 finishes old period (cycles 1..3 unchanged), then 0,0,0,0,0,1 repeating; pend[1] high until that wrap; ch0 unaffected.
- Degenerate settings, ch0:
  - d=5 h=0 → clk_out stays 0, no tick;
  - d=5 h=7 → constant 1 after apply, single tick;
  - d=1 → stopped at 0.
- en[0] drop while clk_out[0]=1 → next cycle clk_out=0, cnt=0; re-raise → restarts 0,0,1,1.
- Assert rst asynchronously mid-period with a pending write → outputs 0 immediately; after release period is d=4 h=2 and the pending write is lost.
- (ALIGN_EN) ch0 d=4, ch1 d=8 h=4 free-running out of phase; pulse align → both outputs low next cycle; ch0 rises 2 cycles after the align edge, ch1 rises 4 cycles after it.
